// File: rtl/mem_stage_access.sv
// MEM stage of the 5-stage MIPS pipeline: performs the EX/MEM load/store against a
// handshaked data memory, stalls upstream while busy, and registers the MEM/WB payload.
module mem_stage_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_in,
    input  logic [2:0]  M_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  dest_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  WB_out,
    output logic [31:0] mem_rdata_out,
    output logic [31:0] alu_out,
    output logic [4:0]  dest_out,
    output logic        misalign_err,
    output logic        timeout_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    // Access copy held stable for the whole BUSY period
    logic [31:0]   r_addr, r_wdata;
    logic          r_we, r_load;
    logic [1:0]    r_wb;
    logic [4:0]    r_dest;

    logic [1:0]    r_wb_out;
    logic [31:0]   r_rdata_out, r_alu_out;
    logic [4:0]    r_dest_out;
    logic          r_misalign, r_timeout;

    logic          w_mem_op, w_aligned, w_unused;
    logic          w_stall, w_req, w_issue, w_upd, w_set_mis, w_set_to;
    logic [1:0]    w_upd_wb;
    logic [31:0]   w_upd_rdata, w_upd_alu;
    logic [4:0]    w_upd_dest;

    assign w_unused  = M_in[2];
    assign w_mem_op  = M_in[1] | M_in[0];
    assign w_aligned = (alu_in[1:0] == 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        w_issue     = 1'b0;
        w_upd       = 1'b0;
        w_set_mis   = 1'b0;
        w_set_to    = 1'b0;
        w_upd_wb    = 2'b00;
        w_upd_rdata = 32'h0;
        w_upd_alu   = alu_in;
        w_upd_dest  = dest_in;
        case (r_state)
            S_IDLE: begin
                if (!w_mem_op) begin
                    w_upd    = 1'b1;
                    w_upd_wb = WB_in;
                end else if (w_aligned) begin
                    w_stall     = 1'b1;
                    w_issue     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end else begin
                    // Misaligned access is dropped and replaced by a bubble
                    w_upd     = 1'b1;
                    w_set_mis = 1'b1;
                end
            end
            S_BUSY: begin
                w_req      = 1'b1;
                w_upd_alu  = r_addr;
                w_upd_dest = r_dest;
                if (dmem_ready) begin
                    w_upd       = 1'b1;
                    w_upd_wb    = r_wb;
                    w_upd_rdata = r_load ? dmem_rdata : 32'h0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_upd       = 1'b1;
                    w_set_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            w_stall = 1'b0;
            w_req   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wb_out    <= 2'b00;
            r_rdata_out <= 32'h0;
            r_alu_out   <= 32'h0;
            r_dest_out  <= 5'd0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_upd) begin
                r_wb_out    <= w_upd_wb;
                r_rdata_out <= w_upd_rdata;
                r_alu_out   <= w_upd_alu;
                r_dest_out  <= w_upd_dest;
            end
            if (w_set_mis) r_misalign <= 1'b1;
            if (w_set_to)  r_timeout  <= 1'b1;
        end
    end

    // MemWrite wins when both MemRead and MemWrite are set
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_addr  <= alu_in;
            r_wdata <= wdata_in;
            r_we    <= M_in[0];
            r_load  <= M_in[1] & ~M_in[0];
            r_wb    <= WB_in;
            r_dest  <= dest_in;
        end
    end

    assign stall         = w_stall;
    assign dmem_req      = w_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign WB_out        = r_wb_out;
    assign mem_rdata_out = r_rdata_out;
    assign alu_out       = r_alu_out;
    assign dest_out      = r_dest_out;
    assign misalign_err  = r_misalign;
    assign timeout_err   = r_timeout;
endmodule

// File: tb/tb_mem_stage_access.sv
// Scoreboard bench for mem_stage_access: stimulus pushes expected MEM/WB payloads,
// a monitor pops and compares on every cycle the stage completes.
module tb_mem_stage_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WB_in;
    logic [2:0]  M_in;
    logic [31:0] alu_in, wdata_in;
    logic [4:0]  dest_in;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  WB_out;
    logic [31:0] mem_rdata_out, alu_out;
    logic [4:0]  dest_out;
    logic        misalign_err, timeout_err;

    always #5 clk = ~clk;

    mem_stage_access #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .WB_in(WB_in), .M_in(M_in), .alu_in(alu_in),
        .wdata_in(wdata_in), .dest_in(dest_in), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .WB_out(WB_out),
        .mem_rdata_out(mem_rdata_out), .alu_out(alu_out), .dest_out(dest_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        ad;   // also compare alu_out/dest_out
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t mk(input logic [1:0] wb, input logic [31:0] rd,
                                input logic [31:0] alu, input logic [4:0] dest, input logic ad);
        exp_t e;
        e.wb = wb; e.rd = rd; e.alu = alu; e.dest = dest; e.ad = ad;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a cycle with stall low outside reset updates MEM/WB at the next edge
    initial begin
        bit   fire;
        exp_t e;
        forever begin
            @(negedge clk);
            fire = (reset === 1'b0) && (stall === 1'b0);
            @(posedge clk);
            #1;
            if (fire) begin
                if (q.size() == 0) begin
                    chk("unexpected_memwb_update", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("WB_out", {30'd0, WB_out}, {30'd0, e.wb});
                    chk("mem_rdata_out", mem_rdata_out, e.rd);
                    if (e.ad) begin
                        chk("alu_out", alu_out, e.alu);
                        chk("dest_out", {27'd0, dest_out}, {27'd0, e.dest});
                    end
                end
            end
        end
    end

    // Drive one instruction, model memory (ready in BUSY cycle ready_at, 0 = never),
    // hold it while stalled, and count stall/req cycles. Returns at posedge+1 after completion.
    task automatic issue(input string tag, input logic [1:0] wb, input logic [2:0] m,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                         input int ready_at, input logic [31:0] rdata, input exp_t e,
                         input int exp_stall, input int exp_req);
        int ns = 0;
        int nr = 0;
        int bc = 0;
        bit done = 0;
        q.push_back(e);
        WB_in = wb; M_in = m; alu_in = alu; wdata_in = wd; dest_in = dst;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (dmem_req) bc++;
            dmem_ready = dmem_req && (bc == ready_at);
            dmem_rdata = rdata;
            @(negedge clk);
            if (stall) ns++;
            if (dmem_req) begin
                nr++;
                chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, m[0]});
                chk({tag, "_addr"}, dmem_addr, alu);
                if (m[0]) chk({tag, "_wdata"}, dmem_wdata, wd);
            end
            if (!stall) done = 1;
        end
        if (!done) chk({tag, "_completion"}, 32'd0, 32'd1);
        chk({tag, "_stall_cycles"}, ns, exp_stall);
        chk({tag, "_req_cycles"}, nr, exp_req);
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; WB_in = 2'b00; M_in = 3'b000; alu_in = 32'h0; wdata_in = 32'h0;
        dest_in = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_WB_out", {30'd0, WB_out}, 32'd0);
        chk("rst_mem_rdata_out", mem_rdata_out, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_dest_out", {27'd0, dest_out}, 32'd0);
        chk("rst_errors", {30'd0, misalign_err, timeout_err}, 32'd0);
        chk("rst_stall_req", {30'd0, stall, dmem_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue("rtype", 2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 32'h0,
              mk(2'b10, 32'h0, 32'h1234, 5'd5, 1'b1), 0, 0);
        // Ready in the 3rd BUSY cycle: stall in IDLE + 2 waiting BUSY cycles
        issue("load", 2'b11, 3'b010, 32'h40, 32'h0, 5'd8, 3, 32'hDEADBEEF,
              mk(2'b11, 32'hDEADBEEF, 32'h40, 5'd8, 1'b1), 3, 3);
        issue("store", 2'b00, 3'b001, 32'h44, 32'hCAFEF00D, 5'd0, 1, 32'h11111111,
              mk(2'b00, 32'h0, 32'h44, 5'd0, 1'b1), 1, 1);
        issue("rdwr", 2'b10, 3'b011, 32'h48, 32'h0BADF00D, 5'd7, 2, 32'h22222222,
              mk(2'b10, 32'h0, 32'h48, 5'd7, 1'b1), 2, 2);
        chk("misalign_before", {31'd0, misalign_err}, 32'd0);
        issue("misalign", 2'b11, 3'b010, 32'h42, 32'h0, 5'd3, 0, 32'h0,
              mk(2'b00, 32'h0, 32'h42, 5'd3, 1'b1), 0, 0);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        issue("rtype2", 2'b10, 3'b000, 32'h99, 32'h0, 5'd2, 0, 32'h0,
              mk(2'b10, 32'h0, 32'h99, 5'd2, 1'b1), 0, 0);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        chk("timeout_before", {31'd0, timeout_err}, 32'd0);
        issue("timeout", 2'b11, 3'b010, 32'h80, 32'h0, 5'd9, 0, 32'h0,
              mk(2'b00, 32'h0, 32'h80, 5'd9, 1'b0), 16, 16);
        chk("timeout_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_back_idle", {31'd0, dmem_req}, 32'd0);

        // Reset during the 2nd BUSY cycle of a load
        WB_in = 2'b11; M_in = 3'b010; alu_in = 32'h50; dest_in = 5'd4;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("busy2_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_busy_stall_req", {30'd0, stall, dmem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("after_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("after_rst_memwb", {WB_out, dest_out, 25'd0}, 32'd0);
        chk("after_rst_alu", alu_out | mem_rdata_out, 32'd0);
        chk("after_rst_errors", {30'd0, misalign_err, timeout_err}, 32'd0);
        reset = 1'b0;
        issue("rtype_after_rst", 2'b10, 3'b000, 32'h5678, 32'h0, 5'd6, 0, 32'h0,
              mk(2'b10, 32'h0, 32'h5678, 5'd6, 1'b1), 0, 0);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
